// File: rtl/cpu_arith_pkg.sv
// Shared arithmetic definitions for the ALU companion units: widths,
// divider FSM encodings and divide-by-zero quotient constants.
package cpu_arith_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam logic [31:0] DBZ_Q_POS = 32'hFFFF_FFFF;
  localparam logic [31:0] DBZ_Q_NEG = 32'h0000_0001;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, trial-subtract
// the divisor magnitude and keep or restore, shifting in the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] rem_quo,
  input  logic [WIDTH:0]   dvs_mag,
  output logic [2*WIDTH:0] rem_quo_next
);

  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    rem     = rem_quo[2*WIDTH:WIDTH];
    quo     = rem_quo[WIDTH-1:0];
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_mag};
    // A set top bit means the subtraction went negative: restore.
    if (trial[WIDTH+1]) begin
      rem_quo_next = {shifted[WIDTH:0], quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_quo_next = {trial[WIDTH:0], quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div32_seq.sv
// Sequential signed divider, one quotient bit per clock, result = {rem, quo}.
// Define DIV32_SEQ_FAST_DBZ_EN to short-circuit divide-by-zero straight to FIX.
module div32_seq
  import cpu_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic                    busy,
  output logic                    done,
  output logic [2*WIDTH-1:0]      result
);

  div_state_e       state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   dvs;
  logic [CNT_W-1:0] count;
  logic             sign_q;
  logic             sign_r;
  logic [2*WIDTH:0] step_next;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] fix_rem;

  // Two's-complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1) as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return u[WIDTH-1] ? (~u + WIDTH'(1)) : u;
  endfunction

  function automatic logic [WIDTH-1:0] negate_if(input logic neg,
                                                 input logic [WIDTH-1:0] v);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_quo      ({rem, quo}),
    .dvs_mag      (dvs),
    .rem_quo_next (step_next)
  );

  assign fix_quo = negate_if(sign_q, quo);
  assign fix_rem = negate_if(sign_r, rem[WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      count  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r <= dividend[WIDTH-1];
            dvs    <= {1'b0, mag(divisor)};
            count  <= '0;
            busy   <= 1'b1;
`ifdef DIV32_SEQ_FAST_DBZ_EN
            // Preload what the full iteration would leave for a zero divisor.
            if (divisor == '0) begin
              rem   <= {1'b0, mag(dividend)};
              quo   <= DBZ_Q_POS[WIDTH-1:0];
              state <= FIX;
            end else begin
              rem   <= '0;
              quo   <= mag(dividend);
              state <= DIV;
            end
`else
            rem   <= '0;
            quo   <= mag(dividend);
            state <= DIV;
`endif
          end
        end
        DIV: begin
          {rem, quo} <= step_next;
          count      <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          result <= {fix_rem, fix_quo};
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq: signed cases, overflow, divide-by-zero,
// ignored start/operand changes, back-to-back start and mid-operation clear.
module tb_div32_seq;
  import cpu_arith_pkg::*;

`ifdef DIV32_SEQ_FAST_DBZ_EN
  localparam int DBZ_LAT = 1;
`else
  localparam int DBZ_LAT = 33;
`endif

  logic               clk = 1'b0;
  logic               clr;
  logic               start;
  logic signed [31:0] dividend;
  logic signed [31:0] divisor;
  logic               busy;
  logic               done;
  logic [63:0]        result;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  div32_seq dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(inout int lat);
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  // Called 1 time unit after an edge; start is sampled at the next edge N.
  task automatic do_div(input string tag, input logic signed [31:0] a,
                        input logic signed [31:0] b, input logic [63:0] exp,
                        input int exp_lat);
    int lat;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    chk({tag, "_busy_start"}, 64'(busy), 64'd1);
    wait_done(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, result, exp);
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    clr      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    clr = 1'b0;
    tick();

    do_div("p100_p7", 32'sd100, 32'sd7, {32'd2, 32'd14}, 33);
    do_div("n100_p7", -32'sd100, 32'sd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);
    do_div("p100_n7", 32'sd100, -32'sd7, {32'h0000_0002, 32'hFFFF_FFF2}, 33);
    do_div("min_n1", 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    do_div("min_p1", 32'h8000_0000, 32'sd1, {32'd0, 32'h8000_0000}, 33);
    do_div("p7_p100", 32'sd7, 32'sd100, {32'd7, 32'd0}, 33);
    do_div("n7_n2", -32'sd7, -32'sd2, {32'hFFFF_FFFF, 32'd3}, 33);
    do_div("p5_z", 32'sd5, 32'sd0, {32'h0000_0005, DBZ_Q_POS}, DBZ_LAT);
    do_div("n5_z", -32'sd5, 32'sd0, {32'hFFFF_FFFB, DBZ_Q_NEG}, DBZ_LAT);

    // Start and operand changes while busy must be ignored.
    dividend = 32'sd100;
    divisor  = 32'sd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    repeat (9) begin
      tick();
      lat++;
    end
    chk("ign_busy_mid", 64'(busy), 64'd1);
    dividend = 32'sd9;
    divisor  = 32'sd3;
    start    = 1'b1;
    tick();
    lat++;
    start    = 1'b0;
    dividend = -32'sd1;
    divisor  = 32'sd5;
    lat--;
    wait_done(lat);
    chk("ign_lat", 64'(lat), 64'd33);
    chk("ign_res", result, {32'd2, 32'd14});
    // Back-to-back: start issued in the done cycle.
    do_div("b2b_9_3", 32'sd9, 32'sd3, {32'd0, 32'd3}, 33);

    // Clear in the middle of an operation aborts it without a done pulse.
    dividend = 32'sd100;
    divisor  = 32'sd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_result", result, 64'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) seen++;
    end
    chk("clr_no_done", 64'(seen), 64'd0);
    do_div("post_clr", 32'sd9, 32'sd3, {32'd0, 32'd3}, 33);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
